// File: rtl/memory_controller.sv
// Byte-wide RAM/IO port owner: serialises IF word fetches and LSB byte/half/word
// loads and stores into little-endian byte transactions, one access at a time.
module memory_controller #(
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        if_flag,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic [31:0] inst,
    output logic        inst_rdy,
    input  logic        lsb_flag,
    input  logic        lsb_r_nw,
    input  logic        load_sign,
    input  logic [1:0]  data_size_to_mc,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_write,
    output logic [31:0] data_read,
    output logic        lsb_enable,
    output logic        data_rdy,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, DONE} state_t;

    state_t      state, state_next;

    logic        pend_valid, pend_r_nw, pend_sign;
    logic [1:0]  pend_size;
    logic [31:0] pend_addr, pend_data;

    logic [31:0] op_addr, op_data, rx_buf;
    logic [2:0]  op_n, cnt;
    logic        op_sign, mem_wr_q;

    logic        lsb_go, sel_r_nw, sel_sign, last_rx, io_stall;
    logic [1:0]  sel_size, rx_idx;
    logic [31:0] sel_addr, sel_data, issue_addr, rx_word, load_ext;

    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            2'd0:    return 3'd1;
            2'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // A request pulsing at this very edge wins over an empty slot.
    assign lsb_go     = pend_valid | lsb_flag;
    assign sel_r_nw   = lsb_flag ? lsb_r_nw        : pend_r_nw;
    assign sel_sign   = lsb_flag ? load_sign       : pend_sign;
    assign sel_size   = lsb_flag ? data_size_to_mc : pend_size;
    assign sel_addr   = lsb_flag ? data_addr       : pend_addr;
    assign sel_data   = lsb_flag ? data_write      : pend_data;

    // Reads are two cycles behind their address, so cnt-2 is the byte arriving now.
    assign issue_addr = op_addr + {29'd0, cnt};
    assign rx_idx     = cnt[1:0] - 2'd2;
    assign last_rx    = (cnt == op_n + 3'd1);
    assign io_stall   = io_buffer_full && (issue_addr >= IO_BASE) && (issue_addr <= IO_BASE + 32'd7);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else if (rdy)
            state <= state_next;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (lsb_go)
                    state_next = sel_r_nw ? LOAD : STORE;
                else if (if_flag && !if_flush)
                    state_next = FETCH;
            end
            FETCH: begin
                if (if_flush)
                    state_next = IDLE;
                else if (last_rx)
                    state_next = DONE;
            end
            LOAD:    if (last_rx) state_next = DONE;
            STORE:   if (cnt == op_n) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_wr  = mem_wr_q & rdy;
        rx_word = rx_buf;
        rx_word[{rx_idx, 3'b000} +: 8] = mem_din;
        case (op_n)
            3'd1:    load_ext = op_sign ? {{24{rx_word[7]}}, rx_word[7:0]}   : {24'd0, rx_word[7:0]};
            3'd2:    load_ext = op_sign ? {{16{rx_word[15]}}, rx_word[15:0]} : {16'd0, rx_word[15:0]};
            default: load_ext = rx_word;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid <= 1'b0;
            pend_r_nw  <= 1'b0;
            pend_sign  <= 1'b0;
            pend_size  <= 2'd0;
            pend_addr  <= '0;
            pend_data  <= '0;
            op_addr    <= '0;
            op_data    <= '0;
            op_n       <= 3'd0;
            op_sign    <= 1'b0;
            cnt        <= 3'd0;
            rx_buf     <= '0;
            inst       <= '0;
            inst_rdy   <= 1'b0;
            data_read  <= '0;
            data_rdy   <= 1'b0;
            lsb_enable <= 1'b0;
            mem_dout   <= 8'd0;
            mem_a      <= '0;
            mem_wr_q   <= 1'b0;
        end else if (rdy) begin
            inst_rdy   <= 1'b0;
            data_rdy   <= 1'b0;
            mem_wr_q   <= 1'b0;
            lsb_enable <= (state == IDLE) && !pend_valid && !lsb_flag;

            // Captured in every state: LSB may pulse one edge after seeing lsb_enable.
            if (lsb_flag) begin
                pend_valid <= 1'b1;
                pend_r_nw  <= lsb_r_nw;
                pend_sign  <= load_sign;
                pend_size  <= data_size_to_mc;
                pend_addr  <= data_addr;
                pend_data  <= data_write;
            end

            case (state)
                IDLE: begin
                    cnt <= 3'd0;
                    if (lsb_go) begin
                        pend_valid <= 1'b0;
                        op_addr    <= sel_addr;
                        op_data    <= sel_data;
                        op_sign    <= sel_sign;
                        op_n       <= byte_count(sel_size);
                    end else if (if_flag && !if_flush) begin
                        op_addr <= if_addr;
                        op_sign <= 1'b0;
                        op_n    <= 3'd4;
                    end
                end
                FETCH, LOAD: begin
                    cnt <= cnt + 3'd1;
                    if (cnt < op_n)
                        mem_a <= issue_addr;
                    if (cnt >= 3'd2)
                        rx_buf <= rx_word;
                    if (last_rx) begin
                        if (state == LOAD) begin
                            data_read <= load_ext;
                            data_rdy  <= 1'b1;
                        end else if (!if_flush) begin
                            inst     <= rx_word;
                            inst_rdy <= 1'b1;
                        end
                    end
                end
                STORE: begin
                    if (cnt < op_n) begin
                        if (!io_stall) begin
                            mem_a    <= issue_addr;
                            mem_dout <= op_data[{cnt[1:0], 3'b000} +: 8];
                            mem_wr_q <= 1'b1;
                            cnt      <= cnt + 3'd1;
                        end
                    end else begin
                        data_rdy <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/memory_controller.md
# memory_controller

Sole owner of the byte-wide RAM/IO port. It serves 32-bit instruction fetches for IF and byte/half/word loads and stores for the load/store buffer, one access at a time. Wider accesses are serialised into little-endian byte transactions. Results come back as one-cycle completion pulses. It sits between IF/LSB and the external `ram`/`io` bus.

## Interface
- `IO_BASE`, 32'h30000: start of the IO window (8 bytes) subject to `io_buffer_full`
- `clk` input 1: system clock, all state on posedge
- `rst_n` input 1: asynchronous, active-low reset
- `rdy` input 1: global enable; low freezes all state
- `if_flag` input 1: IF fetch request, level, held until `inst_rdy` or `if_flush`
- `if_addr` input 32: fetch address
- `if_flush` input 1: branch mispredict; abort any fetch
- `inst` output 32: fetched instruction
- `inst_rdy` output 1: one-cycle pulse, `inst` valid
- `lsb_flag` input 1: one-cycle LSB request pulse
- `lsb_r_nw` input 1: 1 = load, 0 = store
- `load_sign` input 1: 1 = sign-extend, 0 = zero-extend
- `data_size_to_mc` input 2: 0 = byte, 1 = half, 3 = word
- `data_addr` input 32: byte address
- `data_write` input 32: store data (low bytes used)
- `data_read` output 32: extended load result
- `lsb_enable` output 1: controller idle; LSB may issue
- `data_rdy` output 1: one-cycle pulse, load or store complete
- `mem_din` input 8: RAM read byte
- `mem_dout` output 8: RAM write byte
- `mem_a` output 32: RAM byte address
- `mem_wr` output 1: 1 = write `mem_dout` to `mem_a`
- `io_buffer_full` input 1: IO write must not be issued

## Operation
- States: IDLE, FETCH, LOAD, STORE, DONE.
- LSB request slot:
  - `lsb_flag` is captured in any state into a one-entry pending slot (op, sign, size, addr, data).
  - Capture happens even while busy, because LSB samples `lsb_enable` one edge before its pulse arrives.
  - At most one LSB request is ever outstanding.
- Arbitration in IDLE: pending LSB first, then `if_flag`. A new `lsb_flag` at the same edge counts as pending.
- Byte count n:
  - Size 0 → 1, size 1 → 2, size 3 → 4.
  - IF is always 4.
  - Size 2 is treated as 3.
- Byte i goes to address base+i. Byte i occupies result bits [8i+7:8i] (little-endian).
- Load result:
  - Byte and half results are sign-extended when `load_sign`=1, zero-extended otherwise.
  - Word results are returned unchanged.
- Store: byte i of `data_write` is driven on `mem_dout` with `mem_wr`=1 for exactly one cycle.
- IO stall:
  - Applies to a store byte whose address lies in [IO_BASE, IO_BASE+7] while `io_buffer_full`=1.
  - That byte is not issued (`mem_wr`=0) and the byte index holds until the buffer is no longer full.
- Flush behaviour:
  - `if_flush` in FETCH: return to IDLE at the next edge, with no `inst_rdy`.
  - `if_flush` in IDLE: the same-edge `if_flag` is ignored.
  - LSB operations are never aborted. Committed stores must land, and stale loads are discarded by LSB.
- `lsb_enable` = registered. It is 1 only when the state is IDLE, the pending slot is empty and no `lsb_flag` is seen at this edge.
- DONE: completion pulse for one cycle, then IDLE.
- `rdy`=0: hold every register. `mem_wr` is gated to 0 combinationally.

## Timing
- Reset, asynchronous:
  - State IDLE, slot empty.
  - `inst`, `inst_rdy`, `data_read`, `data_rdy`, `lsb_enable`, `mem_dout`, `mem_a`, `mem_wr` all 0.
  - `lsb_enable` rises at the first edge after release.
- RAM read latency: a byte addressed on `mem_a` from edge k is sampled on `mem_din` at edge k+2. Read addresses are issued back-to-back, one per cycle.
- Read request accepted at edge A:
  - `mem_a` = byte i from edge A+1+i.
  - The last byte is sampled and the completion pulse (`inst_rdy` or `data_rdy` with data) is set at edge A+2+n.
  - Word: A+6. Byte: A+3.
- Store accepted at edge A (no stall):
  - Byte i is written at edge A+1+i.
  - `data_rdy` is set at edge A+1+n. Word: A+5.
- Each IO stall cycle delays all later events by one.
- `mem_wr`=0 in every cycle that is not a store byte issue.
- A pulse output is high for exactly one cycle.

## Test plan
- Fetch: `if_flag`, `if_addr`=0x100, RAM[0x100..0x103]=13,05,10,00 → `inst_rdy` once, 6 cycles after acceptance, `inst`=0x00100513.
- Signed load:
  - LB of 0x80 at 0x200, sign=1 → `data_read`=0xFFFFFF80, `data_rdy` at A+3.
  - LHU of 0x8001 → 0x00008001.
- Store word: SW 0xDEADBEEF to 0x400 → writes EF, BE, AD, DE at 0x400–0x403 on consecutive cycles, then `data_rdy` at A+5; a read-back word equals 0xDEADBEEF.
- Arbitration:
  - `lsb_flag` pulses one cycle after a fetch starts → the LSB op is held pending and served right after `inst_rdy`.
  - If both are requested in IDLE, LSB goes first.
- Flush: `if_flush` two cycles into a fetch → no `inst_rdy`, IDLE next cycle, `lsb_enable`=1 after. `if_flush` during a store → the store still completes with `data_rdy`.
- IO and reset:
  - SB to 0x30000 with `io_buffer_full` high for 3 cycles → `mem_wr` stays 0 for those cycles, then one write and `data_rdy` 3 cycles late.
  - Dropping `rst_n` mid-access → all outputs 0 immediately.
